// File: rtl/huffman_pkg.sv
// huffman_pkg: FSM state encoding, parameter legality limits and the
// packing helper shared by the Huffman code generator files.
package huffman_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_SCAN,
    ST_MERGE,
    ST_DONE
  } state_t;

  localparam int NSYM_MIN = 2;
  localparam int NSYM_MAX = 16;

  // True when the parameter set can be built without overflow or truncation.
  function automatic bit params_ok(input int nsym, input int nsamp,
                                   input int cnt_w, input int code_w);
    return (nsym >= NSYM_MIN) && (nsym <= NSYM_MAX) &&
           ((longint'(1) << cnt_w) > longint'(nsamp)) &&
           (code_w >= nsym - 1);
  endfunction

  // LSB position of the field for symbol k (k = 1..NSYM) in a packed bus.
  function automatic int fld_lsb(input int k, input int w);
    return (k - 1) * w;
  endfunction

endpackage

// File: rtl/huffman_if.sv
// huffman_if: sample stream in, histogram and code tables out.
// Optional oor_cnt signal exists only when HUFF_OOR_CNT_EN is defined.
interface huffman_if #(
  parameter int NSYM   = 6,
  parameter int SYM_W  = 8,
  parameter int CNT_W  = 8,
  parameter int CODE_W = 8
);
  logic                   gray_valid;
  logic [SYM_W-1:0]       gray_data;
  logic                   busy;
  logic                   cnt_valid;
  logic [NSYM*CNT_W-1:0]  cnt;
  logic                   code_valid;
  logic [NSYM*CODE_W-1:0] hc;
  logic [NSYM*CODE_W-1:0] m;
`ifdef HUFF_OOR_CNT_EN
  logic [CNT_W-1:0]       oor_cnt;

  modport master (output gray_valid, gray_data,
                  input  busy, cnt_valid, cnt, code_valid, hc, m, oor_cnt);
  modport slave  (input  gray_valid, gray_data,
                  output busy, cnt_valid, cnt, code_valid, hc, m, oor_cnt);
`else
  modport master (output gray_valid, gray_data,
                  input  busy, cnt_valid, cnt, code_valid, hc, m);
  modport slave  (input  gray_valid, gray_data,
                  output busy, cnt_valid, cnt, code_valid, hc, m);
`endif
endinterface

// File: rtl/huffman_hist.sv
// huffman_hist: frame sample counter and per-symbol histogram.
// o_frame_done pulses the cycle after the NSAMP-th sample is accepted.
// HUFF_OOR_CNT_EN adds a counter of out-of-range samples in the frame.
module huffman_hist import huffman_pkg::*; #(
  parameter int NSYM  = 6,
  parameter int NSAMP = 100,
  parameter int SYM_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_accept,
  input  logic                  i_first,
  input  logic [SYM_W-1:0]      i_data,
  output logic [NSYM*CNT_W-1:0] o_cnt,
`ifdef HUFF_OOR_CNT_EN
  output logic [CNT_W-1:0]      o_oor_cnt,
`endif
  output logic                  o_frame_done
);
  localparam int SAMP_W = $clog2(NSAMP + 1);

  logic [SAMP_W-1:0] r_samp;
  logic [SAMP_W-1:0] w_samp_base;
  logic [CNT_W-1:0]  r_cnt [1:NSYM];
  logic              r_frame_done;
  logic              w_in_range;

  // The first sample of a frame restarts counting from zero.
  assign w_samp_base  = i_first ? '0 : r_samp;
  assign w_in_range   = (i_data != '0) && (i_data <= SYM_W'(NSYM));
  assign o_frame_done = r_frame_done;

  // Sample counter; flag the frame end when the last sample goes in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_samp       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= i_accept && (w_samp_base == SAMP_W'(NSAMP - 1));
      if (i_accept) r_samp <= w_samp_base + SAMP_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= NSYM; gi++) begin : g_bin
      // One histogram bin: reload on the first sample, else increment on a hit.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt[gi] <= '0;
        end else if (i_accept) begin
          if (i_first)
            r_cnt[gi] <= (i_data == SYM_W'(gi)) ? CNT_W'(1) : '0;
          else if (i_data == SYM_W'(gi))
            r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
        end
      end
      assign o_cnt[fld_lsb(gi, CNT_W) +: CNT_W] = r_cnt[gi];
    end
  endgenerate

`ifdef HUFF_OOR_CNT_EN
  logic [CNT_W-1:0] r_oor;
  assign o_oor_cnt = r_oor;

  // Out-of-range sample counter, restarted by the first sample of a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_oor <= '0;
    end else if (i_accept) begin
      if (i_first)
        r_oor <= w_in_range ? '0 : CNT_W'(1);
      else if (!w_in_range)
        r_oor <= r_oor + CNT_W'(1);
    end
  end
`else
  logic w_unused_range;
  assign w_unused_range = w_in_range;
`endif

endmodule

// File: rtl/huffman_gen.sv
// huffman_gen: histogram a frame of NSAMP symbols, then build Huffman codes
// by repeated SCAN (find two lightest slots) / MERGE (extend codes) passes.
// Optional HUFF_OOR_CNT_EN exposes the out-of-range sample count.
module huffman_gen import huffman_pkg::*; #(
  parameter int NSYM   = 6,
  parameter int NSAMP  = 100,
  parameter int SYM_W  = 8,
  parameter int CNT_W  = 8,
  parameter int CODE_W = 8
) (
  input  logic clk,
  input  logic reset,
  huffman_if.slave bus
);
  localparam int IDX_W = $clog2(NSYM + 1);
  // One above any real weight, so the first active slot always wins.
  localparam logic [CNT_W:0] W_MAX = {1'b1, {CNT_W{1'b0}}};

  generate
    if (!params_ok(NSYM, NSAMP, CNT_W, CODE_W)) begin : g_bad_params
      $error("huffman_gen: illegal parameter combination");
    end
  endgenerate

  state_t                r_state, w_state_next;
  logic [NSYM*CNT_W-1:0] w_cnt;
  logic                  w_frame_done, w_take, w_accept, w_first;
  logic [IDX_W-1:0]      w_nact, w_lo, w_hi;
  logic [CNT_W-1:0]      w_sum;

  logic [CNT_W-1:0]  r_w   [1:NSYM];
  logic [NSYM-1:0]   r_grp [1:NSYM];   // bit k-1 set: symbol k is in this node
  logic              r_act [1:NSYM];
  logic [CODE_W-1:0] r_hc  [1:NSYM];
  logic [CODE_W-1:0] r_m   [1:NSYM];
  logic [IDX_W-1:0]  r_idx, r_min1, r_min2, r_nact;
  logic [CNT_W:0]    r_min1_w, r_min2_w;

  // Samples are taken whenever the code engine is not running.
  assign w_take   = (r_state == ST_IDLE) || (r_state == ST_COUNT) || (r_state == ST_DONE);
  assign w_accept = bus.gray_valid && w_take && !w_frame_done;
  assign w_first  = w_accept && (r_state != ST_COUNT);

  huffman_hist #(
    .NSYM(NSYM), .NSAMP(NSAMP), .SYM_W(SYM_W), .CNT_W(CNT_W)
  ) u_hist (
    .clk          (clk),
    .reset        (reset),
    .i_accept     (w_accept),
    .i_first      (w_first),
    .i_data       (bus.gray_data),
    .o_cnt        (w_cnt),
`ifdef HUFF_OOR_CNT_EN
    .o_oor_cnt    (bus.oor_cnt),
`endif
    .o_frame_done (w_frame_done)
  );

  // Number of symbols that occurred at least once in the frame.
  always_comb begin
    w_nact = '0;
    for (int k = 1; k <= NSYM; k++)
      if (w_cnt[fld_lsb(k, CNT_W) +: CNT_W] != '0) w_nact = w_nact + IDX_W'(1);
  end

  assign w_lo  = (r_min1 < r_min2) ? r_min1 : r_min2;
  assign w_hi  = (r_min1 < r_min2) ? r_min2 : r_min1;
  assign w_sum = r_w[r_min1] + r_w[r_min2];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; 0 or 1 active symbols need no merging.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_COUNT;
      ST_COUNT: if (w_frame_done) w_state_next = (w_nact > IDX_W'(1)) ? ST_SCAN : ST_DONE;
      ST_SCAN:  if (r_idx == IDX_W'(NSYM)) w_state_next = ST_MERGE;
      ST_MERGE: w_state_next = (r_nact == IDX_W'(2)) ? ST_DONE : ST_SCAN;
      ST_DONE:  w_state_next = w_accept ? ST_COUNT : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Slot table, min tracking and code/mask construction.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= NSYM; k++) begin
        r_w[k] <= '0; r_grp[k] <= '0; r_act[k] <= 1'b0; r_hc[k] <= '0; r_m[k] <= '0;
      end
      r_idx <= '0; r_min1 <= '0; r_min2 <= '0; r_nact <= '0;
      r_min1_w <= W_MAX; r_min2_w <= W_MAX;
    end else begin
      if (w_first) begin
        for (int k = 1; k <= NSYM; k++) begin
          r_hc[k] <= '0; r_m[k] <= '0;
        end
      end
      case (r_state)
        ST_COUNT: if (w_frame_done) begin
          for (int k = 1; k <= NSYM; k++) begin
            r_w[k]   <= w_cnt[fld_lsb(k, CNT_W) +: CNT_W];
            r_grp[k] <= NSYM'(1) << (k - 1);
            r_act[k] <= (w_cnt[fld_lsb(k, CNT_W) +: CNT_W] != '0);
            r_hc[k]  <= '0;
            // A lone active symbol is coded as the single bit "0".
            r_m[k]   <= ((w_nact == IDX_W'(1)) && (w_cnt[fld_lsb(k, CNT_W) +: CNT_W] != '0))
                        ? CODE_W'(1) : '0;
          end
          r_nact <= w_nact; r_idx <= IDX_W'(1);
          r_min1_w <= W_MAX; r_min2_w <= W_MAX;
        end
        ST_SCAN: begin
          // Strict compares keep the lower index on ties.
          if (r_act[r_idx]) begin
            if ({1'b0, r_w[r_idx]} < r_min1_w) begin
              r_min2 <= r_min1; r_min2_w <= r_min1_w;
              r_min1 <= r_idx;  r_min1_w <= {1'b0, r_w[r_idx]};
            end else if ({1'b0, r_w[r_idx]} < r_min2_w) begin
              r_min2 <= r_idx;  r_min2_w <= {1'b0, r_w[r_idx]};
            end
          end
          r_idx <= r_idx + IDX_W'(1);
        end
        ST_MERGE: begin
          // Lightest node's symbols get a 1, runner-up's get a 0, at bit len.
          for (int k = 1; k <= NSYM; k++) begin
            if (r_grp[r_min1][k-1]) begin
              r_hc[k] <= r_hc[k] | (r_m[k] + CODE_W'(1));
              r_m[k]  <= (r_m[k] << 1) | CODE_W'(1);
            end else if (r_grp[r_min2][k-1]) begin
              r_m[k]  <= (r_m[k] << 1) | CODE_W'(1);
            end
          end
          r_w[w_lo]   <= w_sum;
          r_grp[w_lo] <= r_grp[r_min1] | r_grp[r_min2];
          r_act[w_hi] <= 1'b0;
          r_nact <= r_nact - IDX_W'(1); r_idx <= IDX_W'(1);
          r_min1_w <= W_MAX; r_min2_w <= W_MAX;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = w_frame_done || (r_state == ST_SCAN) || (r_state == ST_MERGE);
  assign bus.cnt_valid  = w_frame_done;
  assign bus.code_valid = (r_state == ST_DONE);
  assign bus.cnt        = w_cnt;

  genvar gi;
  generate
    for (gi = 1; gi <= NSYM; gi++) begin : g_pack
      assign bus.hc[fld_lsb(gi, CODE_W) +: CODE_W] = r_hc[gi];
      assign bus.m[fld_lsb(gi, CODE_W) +: CODE_W]  = r_m[gi];
    end
  endgenerate

endmodule

// File: tb/tb_huffman_gen.sv
// tb_huffman_gen: scoreboard bench for huffman_gen (default parameters).
// Build with +define+HUFF_OOR_CNT_EN to also check oor_cnt.
module tb_huffman_gen;
  localparam int NSYM = 6, NSAMP = 100, SYM_W = 8, CNT_W = 8, CODE_W = 8;
  localparam int SW = NSYM * CNT_W, HW = NSYM * CODE_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  huffman_if #(.NSYM(NSYM), .SYM_W(SYM_W), .CNT_W(CNT_W), .CODE_W(CODE_W)) bus();

  huffman_gen #(.NSYM(NSYM), .NSAMP(NSAMP), .SYM_W(SYM_W), .CNT_W(CNT_W), .CODE_W(CODE_W))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [SW-1:0] cnt;
    logic [HW-1:0] hc;
    logic [HW-1:0] m;
    int            lat;
    int            oor;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0, n_fail = 0, n_done = 0, n_expect = 0;
  int cyc = 0, cv_cyc = 0;
  int frame [0:NSAMP-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: cnt checked at cnt_valid, codes and latency at code_valid.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.cnt_valid) begin
        cv_cyc = cyc;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL unexpected_cnt_valid: got cnt_valid with empty scoreboard");
        end else if (bus.cnt !== sb[0].cnt) begin
          n_fail++; $display("FAIL cnt: got %h expected %h", bus.cnt, sb[0].cnt);
        end
      end
      if (bus.code_valid) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL unexpected_code_valid: got code_valid with empty scoreboard");
        end else begin
          e = sb.pop_front();
          if (bus.hc !== e.hc) begin
            n_fail++; $display("FAIL hc: got %h expected %h", bus.hc, e.hc);
          end
          n_tests++;
          if (bus.m !== e.m) begin
            n_fail++; $display("FAIL m: got %h expected %h", bus.m, e.m);
          end
          n_tests++;
          if (cyc - cv_cyc != e.lat) begin
            n_fail++; $display("FAIL latency: got %0d expected %0d", cyc - cv_cyc, e.lat);
          end
`ifdef HUFF_OOR_CNT_EN
          n_tests++;
          if (bus.oor_cnt !== CNT_W'(e.oor)) begin
            n_fail++; $display("FAIL oor_cnt: got %0d expected %0d", bus.oor_cnt, e.oor);
          end
`endif
          $display("[TB] frame done: cnt=%h hc=%h m=%h latency=%0d", bus.cnt, bus.hc, bus.m, cyc - cv_cyc);
        end
        n_done++;
      end
    end
  end

  // Reference Huffman build over the current frame contents.
  function automatic exp_t build_expected();
    exp_t e;
    int c[0:NSYM], w[0:NSYM], grp[0:NSYM], len[0:NSYM], code[0:NSYM];
    bit act[0:NSYM];
    int nact, r, a, b, lo, hi, oor;
    nact = 0; r = 0; oor = 0;
    for (int k = 0; k <= NSYM; k++) begin c[k] = 0; len[k] = 0; code[k] = 0; end
    for (int i = 0; i < NSAMP; i++)
      if (frame[i] >= 1 && frame[i] <= NSYM) c[frame[i]]++; else oor++;
    for (int k = 1; k <= NSYM; k++) begin
      w[k] = c[k]; act[k] = (c[k] != 0); grp[k] = 1 << k;
      if (act[k]) nact++;
    end
    if (nact == 1)
      for (int k = 1; k <= NSYM; k++) if (act[k]) len[k] = 1;
    while (nact > 1) begin
      a = 0; b = 0;
      for (int k = 1; k <= NSYM; k++) if (act[k]) begin
        if (a == 0) a = k;
        else if (w[k] < w[a]) begin b = a; a = k; end
        else if (b == 0 || w[k] < w[b]) b = k;
      end
      for (int s = 1; s <= NSYM; s++) begin
        if ((grp[a] >> s) & 1) begin code[s] |= (1 << len[s]); len[s]++; end
        else if ((grp[b] >> s) & 1) len[s]++;
      end
      lo = (a < b) ? a : b; hi = (a < b) ? b : a;
      w[lo] = w[a] + w[b]; grp[lo] = grp[a] | grp[b]; act[hi] = 0;
      nact--; r++;
    end
    e.cnt = '0; e.hc = '0; e.m = '0;
    for (int k = 1; k <= NSYM; k++) begin
      e.cnt[(k-1)*CNT_W +: CNT_W] = CNT_W'(c[k]);
      e.hc[(k-1)*CODE_W +: CODE_W] = CODE_W'(code[k]);
      e.m[(k-1)*CODE_W +: CODE_W]  = CODE_W'((1 << len[k]) - 1);
    end
    e.lat = 1 + r * (NSYM + 1);
    e.oor = oor;
    return e;
  endfunction

  task automatic shuffle_frame();
    int j, t;
    for (int i = NSAMP - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = frame[i]; frame[i] = frame[j]; frame[j] = t;
    end
  endtask

  task automatic random_frame();
    for (int i = 0; i < NSAMP; i++) frame[i] = $urandom_range(1, NSYM);
  endtask

  task automatic push(input exp_t e);
    sb.push_back(e); n_expect++;
  endtask

  task automatic drive_sample(input int s);
    bus.gray_valid = 1'b1;
    bus.gray_data  = SYM_W'(s);
    @(posedge clk); #1;
    bus.gray_valid = 1'b0;
  endtask

  task automatic drive_frame(input int n);
    for (int i = 0; i < n; i++) drive_sample(frame[i]);
  endtask

  task automatic wait_done(input int target, output bit ok);
    for (int i = 0; i < 600 && n_done < target; i++) @(posedge clk);
    ok = (n_done >= target);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if ({bus.busy, bus.cnt_valid, bus.code_valid} !== 3'b000) begin
      n_fail++; $display("FAIL %s_ctrl: got busy/cnt_valid/code_valid=%b expected 000", name,
                         {bus.busy, bus.cnt_valid, bus.code_valid});
    end
    n_tests++;
    if ({bus.cnt, bus.hc, bus.m} !== '0) begin
      n_fail++; $display("FAIL %s_data: got cnt=%h hc=%h m=%h expected all 0", name, bus.cnt, bus.hc, bus.m);
    end
`ifdef HUFF_OOR_CNT_EN
    n_tests++;
    if (bus.oor_cnt !== '0) begin
      n_fail++; $display("FAIL %s_oor: got %0d expected 0", name, bus.oor_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_spec_example();
    int cc [0:5];
    int idx;
    bit ok;
    exp_t e;
    cc = '{40, 25, 15, 10, 6, 4};
    idx = 0;
    for (int s = 0; s < 6; s++)
      for (int n = 0; n < cc[s]; n++) begin frame[idx] = s + 1; idx++; end
    shuffle_frame();
    e.cnt = {8'd4, 8'd6, 8'd10, 8'd15, 8'd25, 8'd40};
    e.hc  = {8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
    e.m   = {8'h1F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
    e.lat = 36; e.oor = 0;
    push(e);
    drive_frame(NSAMP);
    wait_done(n_expect, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL spec_example_timeout: got no code_valid expected one"); end
  endtask

  task automatic test_single_symbol();
    bit ok;
    exp_t e;
    for (int i = 0; i < NSAMP; i++) frame[i] = 3;
    e.cnt = {8'd0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0};
    e.hc  = '0;
    e.m   = {8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
    e.lat = 1; e.oor = 0;
    push(e);
    drive_frame(NSAMP);
    wait_done(n_expect, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: got no code_valid expected one"); end
  endtask

  task automatic test_ties();
    bit ok;
    int l, mx, mn;
    for (int i = 0; i < 96; i++) frame[i] = (i % NSYM) + 1;
    for (int i = 96; i < NSAMP; i++) frame[i] = 0;
    shuffle_frame();
    push(build_expected());
    drive_frame(NSAMP);
    wait_done(n_expect, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ties_timeout: got no code_valid expected one"); end
    mx = 0; mn = 99;
    for (int k = 1; k <= NSYM; k++) begin
      l = $countones(bus.m[(k-1)*CODE_W +: CODE_W]);
      if (l > mx) mx = l;
      if (l < mn) mn = l;
    end
    n_tests++;
    if (mx - mn > 1 || mn < 1) begin
      n_fail++; $display("FAIL ties_length_spread: got min %0d max %0d expected spread <= 1", mn, mx);
    end
  endtask

  task automatic test_out_of_range();
    bit ok;
    int sum;
    random_frame();
    for (int i = 0; i < 10; i++) frame[i] = (i % 2 == 0) ? 0 : 9;
    shuffle_frame();
    push(build_expected());
    drive_frame(NSAMP);
    wait_done(n_expect, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL oor_timeout: got no code_valid expected one"); end
    sum = 0;
    for (int k = 1; k <= NSYM; k++) sum += int'(bus.cnt[(k-1)*CNT_W +: CNT_W]);
    n_tests++;
    if (sum != 90) begin n_fail++; $display("FAIL oor_cnt_sum: got %0d expected 90", sum); end
`ifdef HUFF_OOR_CNT_EN
    n_tests++;
    if (bus.oor_cnt !== CNT_W'(10)) begin
      n_fail++; $display("FAIL oor_port: got %0d expected 10", bus.oor_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    bit ok;
    int i;
    random_frame();
    push(build_expected());
    drive_frame(NSAMP);
    // Keep offering samples while the engine is busy; they must be ignored.
    bus.gray_valid = 1'b1;
    bus.gray_data  = SYM_W'(1);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_frame: got %b expected 1", bus.busy); end
    repeat (20) @(posedge clk);
    #1;
    bus.gray_valid = 1'b0;
    for (i = 0; i < 200 && bus.code_valid !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (bus.code_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_timeout: got code_valid=%b expected 1", bus.code_valid);
    end
    // Second frame starts in the same cycle code_valid is shown.
    random_frame();
    push(build_expected());
    drive_frame(NSAMP);
    wait_done(n_expect, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_second_timeout: got no code_valid expected one"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    // Abort during COUNT.
    random_frame();
    drive_frame(50);
    pulse_reset();
    check_zero("reset_count");
    random_frame();
    push(build_expected());
    drive_frame(NSAMP);
    wait_done(n_expect, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL after_count_reset_timeout: got no code_valid expected one"); end
    // Abort during the first MERGE, NSYM+1 cycles after cnt_valid.
    random_frame();
    push(build_expected());
    drive_frame(NSAMP);
    n_tests++;
    if (bus.cnt_valid !== 1'b1) begin
      n_fail++; $display("FAIL cnt_valid_timing: got %b expected 1", bus.cnt_valid);
    end
    repeat (NSYM + 1) @(posedge clk);
    #1;
    pulse_reset();
    check_zero("reset_merge");
    sb.delete();
    n_expect--;
    random_frame();
    push(build_expected());
    drive_frame(NSAMP);
    wait_done(n_expect, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL after_merge_reset_timeout: got no code_valid expected one"); end
  endtask

  initial begin
    bus.gray_valid = 1'b0;
    bus.gray_data  = '0;
    test_reset();
    test_spec_example();
    test_single_symbol();
    test_ties();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
